// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the keyboard. The sequence is: inhibit the clock,
// request-to-send, an 11-bit frame clocked by the device, then the ACK check.
// It drives the open-drain PS2_CLK/PS2_DAT pins through output-enable lines only.
// Optional feature: define PS2_TX_RETRY_EN to retry a failed frame up to
// MAX_RETRY times before reporting oERR.
`timescale 1ns/1ps

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int MAX_RETRY      = 2
`endif
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iSEND,
    output logic       oREADY,
    output logic       oDONE,
    output logic       oERR,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DAT_OE
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        TX,
        ACK,
        WAITIDLE,
        FAIL
    } stateT;

    stateT state;
    stateT nextState;

    logic [1:0]       clkSync;
    logic [1:0]       datSync;
    logic             clkPrev;
    logic             clkS;
    logic             datS;
    logic             fe;

    logic [8:0]       dataLatch;
    logic [8:0]       shiftReg;
    logic [3:0]       bitIdx;
    logic             datOe;
    logic [INH_W-1:0] inhCnt;
    logic [TO_W-1:0]  toCnt;
    logic             timeout;
    logic             accept;
    logic             retryAllowed;

    assign clkS    = clkSync[1];
    assign datS    = datSync[1];
    assign fe      = clkPrev & ~clkS;
    assign timeout = (toCnt == TO_LAST);
    assign accept  = (state == IDLE) && iSEND;

    // Bring the asynchronous pin levels into the iCLK domain; idle level is high.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            clkSync <= 2'b11;
            datSync <= 2'b11;
            clkPrev <= 1'b1;
        end else begin
            clkSync <= {clkSync[0], iPS2_CLK};
            datSync <= {datSync[0], iPS2_DAT};
            clkPrev <= clkS;
        end
    end

    // State register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and line/handshake outputs, all decoded from the current state.
    always_comb begin
        nextState   = state;
        oREADY      = 1'b0;
        oDONE       = 1'b0;
        oERR        = 1'b0;
        oPS2_CLK_OE = 1'b0;
        oPS2_DAT_OE = 1'b0;
        case (state)
            IDLE: begin
                oREADY = 1'b1;
                if (iSEND) begin
                    nextState = INHIBIT;
                end
            end
            INHIBIT: begin
                oPS2_CLK_OE = 1'b1;
                if (inhCnt == INH_LAST) begin
                    nextState = START;
                end
            end
            START: begin
                oPS2_CLK_OE = 1'b1;
                oPS2_DAT_OE = 1'b1;
                nextState   = TX;
            end
            TX: begin
                oPS2_DAT_OE = datOe;
                if (fe) begin
                    if (bitIdx == 4'd9) begin
                        nextState = ACK;
                    end
                end else if (timeout) begin
                    nextState = FAIL;
                end
            end
            ACK: begin
                if (fe) begin
                    nextState = datS ? FAIL : WAITIDLE;
                end else if (timeout) begin
                    nextState = FAIL;
                end
            end
            WAITIDLE: begin
                if (clkS && datS) begin
                    oDONE     = 1'b1;
                    nextState = IDLE;
                end else if (!fe && timeout) begin
                    nextState = FAIL;
                end
            end
            FAIL: begin
                if (retryAllowed) begin
                    nextState = INHIBIT;
                end else begin
                    oERR      = 1'b1;
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Latch the byte with odd parity on accept and shift it out one bit per device falling edge.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            dataLatch <= 9'd0;
            shiftReg  <= 9'd0;
            bitIdx    <= 4'd0;
            datOe     <= 1'b0;
        end else begin
            if (accept) begin
                dataLatch <= {~^iDATA, iDATA};
            end
            case (state)
                START: begin
                    shiftReg <= dataLatch;
                    bitIdx   <= 4'd0;
                    datOe    <= 1'b1;
                end
                TX: begin
                    if (fe) begin
                        if (bitIdx < 4'd9) begin
                            datOe    <= ~shiftReg[0];
                            shiftReg <= {1'b1, shiftReg[8:1]};
                        end else begin
                            datOe <= 1'b0;
                        end
                        bitIdx <= bitIdx + 4'd1;
                    end
                end
                default: begin
                    datOe <= 1'b0;
                end
            endcase
        end
    end

    // Inhibit length counter and the inter-edge watchdog, which restarts on each edge and state change.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            inhCnt <= '0;
            toCnt  <= '0;
        end else begin
            if (state == INHIBIT && nextState == INHIBIT) begin
                inhCnt <= inhCnt + INH_W'(1);
            end else begin
                inhCnt <= '0;
            end
            if (nextState != state || fe || !(state inside {TX, ACK, WAITIDLE})) begin
                toCnt <= '0;
            end else begin
                toCnt <= toCnt + TO_W'(1);
            end
        end
    end

`ifdef PS2_TX_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RETRY_W-1:0] retryCnt;

    assign retryAllowed = (retryCnt < RETRY_W'(MAX_RETRY));

    // Count retries of the current byte; a fresh accept or a successful frame starts over.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            retryCnt <= '0;
        end else if (accept || oDONE) begin
            retryCnt <= '0;
        end else if (state == FAIL && retryAllowed) begin
            retryCnt <= retryCnt + RETRY_W'(1);
        end
    end
`else
    assign retryAllowed = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed testbench for ps2_host_tx with a simple open-drain keyboard model.
// Build with PS2_TX_RETRY_EN defined to exercise the retry variant.
`timescale 1ns/1ps

module tb_ps2_host_tx;

    localparam int INH = 8;
    localparam int TO  = 200;
`ifdef PS2_TX_RETRY_EN
    localparam int EXP_ATTEMPTS = 3;
    localparam int EXP_TO_WAIT  = 620;
`else
    localparam int EXP_ATTEMPTS = 1;
    localparam int EXP_TO_WAIT  = 200;
`endif

    logic       iCLK = 1'b0;
    logic       iRST;
    logic [7:0] iDATA;
    logic       iSEND;
    logic       oREADY;
    logic       oDONE;
    logic       oERR;
    logic       oPS2_CLK_OE;
    logic       oPS2_DAT_OE;
    logic       devClk;
    logic       devDat;
    logic       busClk;
    logic       busDat;

    int checks        = 0;
    int failures      = 0;
    int doneCount     = 0;
    int errCount      = 0;
    int inhibitStarts = 0;
    logic clkOePrev   = 1'b0;

    assign busClk = devClk & ~oPS2_CLK_OE;
    assign busDat = devDat & ~oPS2_DAT_OE;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
`ifdef PS2_TX_RETRY_EN
        ,
        .MAX_RETRY(2)
`endif
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iDATA(iDATA),
        .iSEND(iSEND),
        .oREADY(oREADY),
        .oDONE(oDONE),
        .oERR(oERR),
        .iPS2_CLK(busClk),
        .iPS2_DAT(busDat),
        .oPS2_CLK_OE(oPS2_CLK_OE),
        .oPS2_DAT_OE(oPS2_DAT_OE)
    );

    // 100 MHz system clock.
    always #5 iCLK = ~iCLK;

    // Count handshake pulses and inhibit starts on the inactive edge.
    always @(negedge iCLK) begin
        if (oDONE) doneCount++;
        if (oERR) errCount++;
        if (oPS2_CLK_OE && !clkOePrev) inhibitStarts++;
        clkOePrev = oPS2_CLK_OE;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        @(negedge iCLK);
        iDATA = data;
        iSEND = 1'b1;
        @(posedge iCLK);
        #1;
        iSEND = 1'b0;
    endtask

    // Measure the inhibit and start-bit phases; optionally poke a second request mid-inhibit.
    task automatic measureRequest(output int inh, output int st, input int pokeAt);
        int n;
        inh = 0;
        st  = 0;
        n   = 0;
        while (oPS2_CLK_OE && n < 100) begin
            if (!oPS2_DAT_OE) inh++;
            else st++;
            if (n == pokeAt) begin
                iSEND = 1'b1;
                iDATA = 8'hAA;
            end else begin
                iSEND = 1'b0;
            end
            tick(1);
            n++;
        end
        iSEND = 1'b0;
    endtask

    // Device generates count clock pulses, reading the data line just before each rising edge.
    task automatic deviceClocks(input int count, output logic [9:0] bits);
        bits = 10'd0;
        tick(10);
        for (int k = 0; k < count; k++) begin
            devClk = 1'b0;
            tick(10);
            bits[k] = busDat;
            devClk = 1'b1;
            tick(10);
        end
    endtask

    // Device drives (or withholds) the ACK bit around the 11th falling edge.
    task automatic deviceAck(input logic ack);
        devDat = ~ack;
        tick(10);
        devClk = 1'b0;
        tick(10);
        devClk = 1'b1;
        tick(2);
        devDat = 1'b1;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (!oREADY && n < 400) begin
            tick(1);
            n++;
        end
        checkOutput(tag, 32'(oREADY), 32'd1);
    endtask

    initial begin
        int inh;
        int st;
        int n;
        int d0;
        int e0;
        int s0;
        logic [9:0] bits;

        iRST   = 1'b1;
        iSEND  = 1'b0;
        iDATA  = 8'h00;
        devClk = 1'b1;
        devDat = 1'b1;
        tick(3);
        checkOutput("rst_ready", 32'(oREADY), 32'd1);
        checkOutput("rst_done", 32'(oDONE), 32'd0);
        checkOutput("rst_err", 32'(oERR), 32'd0);
        checkOutput("rst_clk_oe", 32'(oPS2_CLK_OE), 32'd0);
        checkOutput("rst_dat_oe", 32'(oPS2_DAT_OE), 32'd0);
        iRST = 1'b0;
        tick(5);

        $display("[TB] send 0xED");
        d0 = doneCount;
        e0 = errCount;
        applyStimulus(8'hED);
        checkOutput("ed_ready_low", 32'(oREADY), 32'd0);
        measureRequest(inh, st, -1);
        checkOutput("ed_inhibit_len", 32'(inh), 32'd8);
        checkOutput("ed_start_len", 32'(st), 32'd1);
        deviceClocks(10, bits);
        checkOutput("ed_bits", 32'(bits), 32'h3ED);
        deviceAck(1'b1);
        waitIdle("ed_idle");
        checkOutput("ed_done", 32'(doneCount - d0), 32'd1);
        checkOutput("ed_no_err", 32'(errCount - e0), 32'd0);

        $display("[TB] send 0xF4");
        d0 = doneCount;
        e0 = errCount;
        applyStimulus(8'hF4);
        measureRequest(inh, st, -1);
        deviceClocks(10, bits);
        checkOutput("f4_bits", 32'(bits), 32'h2F4);
        deviceAck(1'b1);
        waitIdle("f4_idle");
        checkOutput("f4_done", 32'(doneCount - d0), 32'd1);
        checkOutput("f4_no_err", 32'(errCount - e0), 32'd0);

        $display("[TB] silent device timeout");
        e0 = errCount;
        d0 = doneCount;
        applyStimulus(8'h11);
        measureRequest(inh, st, -1);
        n = 0;
        while (!oERR && n < 1000) begin
            tick(1);
            n++;
        end
        checkOutput("to_wait", 32'(n), 32'(EXP_TO_WAIT));
        tick(1);
        checkOutput("to_ready", 32'(oREADY), 32'd1);
        checkOutput("to_clk_oe", 32'(oPS2_CLK_OE), 32'd0);
        checkOutput("to_dat_oe", 32'(oPS2_DAT_OE), 32'd0);
        checkOutput("to_err", 32'(errCount - e0), 32'd1);
        checkOutput("to_no_done", 32'(doneCount - d0), 32'd0);

        $display("[TB] missing ACK");
        e0 = errCount;
        d0 = doneCount;
        s0 = inhibitStarts;
        applyStimulus(8'h3C);
        measureRequest(inh, st, -1);
        deviceClocks(10, bits);
        deviceAck(1'b0);
`ifdef PS2_TX_RETRY_EN
        for (int a = 1; a < EXP_ATTEMPTS; a++) begin
            checkOutput("nack_early_err", 32'(errCount - e0), 32'd0);
            n = 0;
            while (!oPS2_CLK_OE && n < 50) begin
                tick(1);
                n++;
            end
            n = 0;
            while (oPS2_CLK_OE && n < 50) begin
                tick(1);
                n++;
            end
            deviceClocks(10, bits);
            deviceAck(1'b0);
        end
`endif
        waitIdle("nack_idle");
        tick(20);
        checkOutput("nack_attempts", 32'(inhibitStarts - s0), 32'(EXP_ATTEMPTS));
        checkOutput("nack_err", 32'(errCount - e0), 32'd1);
        checkOutput("nack_no_done", 32'(doneCount - d0), 32'd0);

        $display("[TB] reset during 0x55 frame");
        e0 = errCount;
        applyStimulus(8'h55);
        measureRequest(inh, st, -1);
        deviceClocks(4, bits);
        checkOutput("r55_low_bits", 32'(bits[3:0]), 32'h5);
        devClk = 1'b0;
        tick(1);
        checkOutput("r55_dat_before", 32'(oPS2_DAT_OE), 32'd1);
        #2;
        iRST = 1'b1;
        #1;
        checkOutput("r55_clk_oe", 32'(oPS2_CLK_OE), 32'd0);
        checkOutput("r55_dat_oe", 32'(oPS2_DAT_OE), 32'd0);
        checkOutput("r55_ready", 32'(oREADY), 32'd1);
        tick(2);
        iRST   = 1'b0;
        devClk = 1'b1;
        tick(10);
        checkOutput("r55_no_err", 32'(errCount - e0), 32'd0);

        d0 = doneCount;
        applyStimulus(8'h00);
        measureRequest(inh, st, -1);
        checkOutput("z00_inhibit_len", 32'(inh), 32'd8);
        deviceClocks(10, bits);
        checkOutput("z00_bits", 32'(bits), 32'h300);
        deviceAck(1'b1);
        waitIdle("z00_idle");
        checkOutput("z00_done", 32'(doneCount - d0), 32'd1);

        $display("[TB] request while busy");
        d0 = doneCount;
        s0 = inhibitStarts;
        applyStimulus(8'hED);
        measureRequest(inh, st, 3);
        deviceClocks(10, bits);
        checkOutput("busy_bits", 32'(bits), 32'h3ED);
        deviceAck(1'b1);
        waitIdle("busy_idle");
        tick(40);
        checkOutput("busy_done", 32'(doneCount - d0), 32'd1);
        checkOutput("busy_one_frame", 32'(inhibitStarts - s0), 32'd1);
        checkOutput("busy_ready", 32'(oREADY), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
